// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler: per-channel duty targets are accepted over a valid/ready
// handshake. On every fade tick one shared ramp engine sweeps all channels,
// one per cycle, moving each channel's current duty toward its target by at
// most STEP. The current duties drive a bank of PWM generators.
module pwm_fade_scheduler #(
  parameter int CHANNELS = 8,
  parameter int DUTY_W   = 16,
  parameter int MAX_DUTY = 14000,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 125000,
  parameter int CHAN_W   = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [CHAN_W-1:0]            req_chan,
  input  logic [DUTY_W-1:0]            req_target,
  output logic                         req_err,
  output logic [CHANNELS*DUTY_W-1:0]   duty_flat,
  output logic [CHANNELS-1:0]          ch_busy,
  output logic                         all_idle
);

  localparam int IDX_W  = $clog2(CHANNELS);
  localparam int TCNT_W = $clog2(TICK_DIV);
  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(MAX_DUTY);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [TCNT_W-1:0]   tcnt;
  logic                tick;
  logic [DUTY_W-1:0]   cur [CHANNELS];
  logic [DUTY_W-1:0]   tgt [CHANNELS];
  logic [DUTY_W-1:0]   sel_cur, sel_tgt, cur_nxt, tgt_clamped;
  logic [DUTY_W:0]     cur_x, tgt_x, diff, stp, nxt_x;
  logic                accept, chan_ok;

  assign tick        = (tcnt == TCNT_W'(TICK_DIV - 1));
  assign accept      = req_valid && req_ready;
  assign chan_ok     = ({1'b0, req_chan} < (CHAN_W+1)'(CHANNELS));
  assign tgt_clamped = (req_target > MAX_D) ? MAX_D : req_target;

  // Free-running fade tick divider; runs in every state so no tick is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + TCNT_W'(1);
  end

  // FSM state and sweep index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: a tick launches a CHANNELS-cycle sweep; ready only in IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (tick) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end
      end
      SWEEP: begin
        if (idx == IDX_W'(CHANNELS - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ramp engine: step the visited channel toward its target without overshoot.
  always_comb begin
    sel_cur = '0;
    sel_tgt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_cur = cur[i];
        sel_tgt = tgt[i];
      end
    end
    cur_x = {1'b0, sel_cur};
    tgt_x = {1'b0, sel_tgt};
    diff  = '0;
    stp   = '0;
    nxt_x = cur_x;
    if (cur_x < tgt_x) begin
      diff  = tgt_x - cur_x;
      stp   = (diff < STEP_X) ? diff : STEP_X;
      nxt_x = cur_x + stp;
    end else if (cur_x > tgt_x) begin
      diff  = cur_x - tgt_x;
      stp   = (diff < STEP_X) ? diff : STEP_X;
      nxt_x = cur_x - stp;
    end
    cur_nxt = nxt_x[DUTY_W-1:0];
  end

  // Current duties, targets and the bad-channel error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
      req_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (state == SWEEP && idx == IDX_W'(i))
          cur[i] <= cur_nxt;
        if (accept && chan_ok && req_chan == CHAN_W'(i))
          tgt[i] <= tgt_clamped;
      end
      req_err <= accept && !chan_ok;
    end
  end

  // Status decode and flattened duty bus straight from the registers.
  always_comb begin
    duty_flat = '0;
    ch_busy   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      duty_flat[i*DUTY_W +: DUTY_W] = cur[i];
      ch_busy[i]                    = (cur[i] != tgt[i]);
    end
    all_idle = ~|ch_busy;
  end

endmodule
